// File: rtl/defs.sv
// Shared types for the load/store stage: pipeline instruction/memory types, FSM states,
// and the store-lane / alignment helpers used when a request is launched.
package defs;

  typedef enum logic [3:0] {
    NONE   = 4'd0,
    ALU    = 4'd1,
    LOAD   = 4'd2,
    STORE  = 4'd3,
    BRANCH = 4'd4,
    JAL    = 4'd5,
    JALR   = 4'd6,
    LUI    = 4'd7,
    AUIPC  = 4'd8
  } instr_type_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'd0,
    MEM_H  = 3'd1,
    MEM_W  = 3'd2,
    MEM_BU = 3'd3,
    MEM_HU = 3'd4
  } mem_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  function automatic logic is_misaligned(input mem_type_t mt, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (mt)
      MEM_H, MEM_HU: mis = off[0];
      MEM_W:         mis = |off;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_strb(input mem_type_t mt, input logic [1:0] off);
    logic [3:0] strb;
    strb = '0;
    case (mt)
      MEM_B, MEM_BU: strb = 4'b0001 << off;
      MEM_H, MEM_HU: strb = 4'b0011 << off;
      MEM_W:         strb = '1;
      default:       strb = '0;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] store_wdata(input mem_type_t mt, input logic [31:0] rs2);
    logic [31:0] wd;
    wd = rs2;
    case (mt)
      MEM_B, MEM_BU: wd = {4{rs2[7:0]}};
      MEM_H, MEM_HU: wd = {2{rs2[15:0]}};
      default:       wd = rs2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/memory_access_load_extract.sv
// Load-lane selection: picks the byte/half addressed by the latched offset out of
// the returned memory word and sign- or zero-extends it to 32 bits.
module load_extract
  import defs::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  mem_type_t   mem_type_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata_i >> {off_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = shifted[15:0];
    data_o   = rdata_i;
    case (mem_type_i)
      MEM_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  data_o = {24'h000000, byte_sel};
      MEM_H:   data_o = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Load/store pipeline stage: launches aligned byte/half/word accesses on a valid/ready
// data port, stalls upstream while busy, and returns load or ALU results to writeback.
module memory_access
  import defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  instr_type_t in_instr_type,
  input  mem_type_t   in_mem_type,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_res,
  output logic        stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        out_wb_en,
  output logic [4:0]  out_dest,
  output logic [31:0] out_data,
  output logic        out_misaligned
);

  mem_state_t  state_q, state_d;
  logic [1:0]  off_q, off_d;
  mem_type_t   mt_q, mt_d;
  logic [4:0]  dest_q, dest_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  odest_q, odest_d;
  logic [31:0] odata_q, odata_d;
  logic        mis_q, mis_d;
  logic [31:0] load_val;

  load_extract u_load_extract (
    .rdata_i    (dmem_rdata),
    .off_i      (off_q),
    .mem_type_i (mt_q),
    .data_o     (load_val)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    mt_d    = mt_q;
    dest_d  = dest_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wb_en_d = 1'b0;
    mis_d   = 1'b0;
    odest_d = odest_q;
    odata_d = odata_q;
    case (state_q)
      IDLE: begin
        case (in_instr_type)
          NONE, BRANCH: ;
          LOAD, STORE: begin
            if (is_misaligned(in_mem_type, in_res[1:0])) begin
              mis_d = 1'b1;
            end else begin
              off_d   = in_res[1:0];
              mt_d    = in_mem_type;
              dest_d  = in_dest;
              we_d    = (in_instr_type == STORE);
              addr_d  = {in_res[31:2], 2'b00};
              wdata_d = (in_instr_type == STORE) ? store_wdata(in_mem_type, in_rs2_data) : '0;
              wstrb_d = (in_instr_type == STORE) ? store_strb(in_mem_type, in_res[1:0]) : '0;
              state_d = REQ;
            end
          end
          default: begin
            wb_en_d = (in_dest != 5'd0);
            odest_d = in_dest;
            odata_d = in_res;
          end
        endcase
      end
      REQ: begin
        // Stores are posted: the handshake alone retires them.
        if (dmem_req_ready) state_d = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          wb_en_d = (dest_q != 5'd0);
          odest_d = dest_q;
          odata_d = load_val;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      mt_q    <= MEM_W;
      dest_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wb_en_q <= 1'b0;
      odest_q <= '0;
      odata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      mt_q    <= mt_d;
      dest_q  <= dest_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wb_en_q <= wb_en_d;
      odest_q <= odest_d;
      odata_q <= odata_d;
      mis_q   <= mis_d;
    end
  end

  assign stall          = (state_q != IDLE);
  assign dmem_req_valid = (state_q == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;
  assign out_wb_en      = wb_en_q;
  assign out_dest       = odest_q;
  assign out_data       = odata_q;
  assign out_misaligned = mis_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for the load/store stage: directed scenarios plus randomized operations checked
// against an arithmetic model of lane selection, extension, strobes and alignment.
module tb_memory_access;
  import defs::*;

  logic        clk = 1'b0;
  logic        rst;
  instr_type_t in_instr_type;
  mem_type_t   in_mem_type;
  logic [4:0]  in_dest;
  logic [31:0] in_rs2_data;
  logic [31:0] in_res;
  logic        stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        out_wb_en;
  logic [4:0]  out_dest;
  logic [31:0] out_data;
  logic        out_misaligned;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  memory_access dut (
    .clk            (clk),
    .rst            (rst),
    .in_instr_type  (in_instr_type),
    .in_mem_type    (in_mem_type),
    .in_dest        (in_dest),
    .in_rs2_data    (in_rs2_data),
    .in_res         (in_res),
    .stall          (stall),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_wstrb     (dmem_wstrb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
    .out_wb_en      (out_wb_en),
    .out_dest       (out_dest),
    .out_data       (out_data),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: access size in bytes, then plain arithmetic on byte lanes.
  function automatic int unsigned m_size(input mem_type_t mt);
    if (mt == MEM_B || mt == MEM_BU) return 1;
    if (mt == MEM_H || mt == MEM_HU) return 2;
    return 4;
  endfunction

  function automatic bit m_misaligned(input logic [31:0] addr, input mem_type_t mt);
    return (addr % m_size(mt)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                         input mem_type_t mt);
    longint unsigned v, lim;
    int unsigned sz;
    sz  = m_size(mt);
    v   = longint'(word) >> (8 * (addr % 4));
    lim = 64'd1 << (8 * sz);
    v   = v % lim;
    if ((mt == MEM_B || mt == MEM_H) && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] addr, input mem_type_t mt);
    logic [3:0] s;
    int unsigned off;
    s   = '0;
    off = addr % 4;
    for (int unsigned i = 0; i < 4; i++)
      if (i >= off && i < off + m_size(mt)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input mem_type_t mt);
    logic [31:0] w;
    for (int unsigned i = 0; i < 4; i++)
      w[8*i +: 8] = 8'((rs2 >> (8 * (i % m_size(mt)))) & 32'hFF);
    return w;
  endfunction

  // Drives one instruction from IDLE and follows it to completion, checking every cycle.
  task automatic run_op(input instr_type_t it, input mem_type_t mt, input logic [4:0] dest,
                        input logic [31:0] rs2, input logic [31:0] res,
                        input int unsigned rdy_lat, input int unsigned rsp_lat,
                        input logic [31:0] rdata, input string tag);
    bit          is_mem, is_st;
    logic [31:0] exp_addr, exp_wd, exp_ld;
    logic [3:0]  exp_strb;
    is_mem   = (it == LOAD || it == STORE);
    is_st    = (it == STORE);
    exp_addr = {res[31:2], 2'b00};
    exp_strb = is_st ? m_strb(res, mt) : 4'h0;
    exp_wd   = m_wdata(rs2, mt);
    exp_ld   = m_load(rdata, res, mt);

    in_instr_type = it; in_mem_type = mt; in_dest = dest;
    in_rs2_data = rs2; in_res = res;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    in_instr_type = NONE;

    if (!is_mem) begin
      bit wb;
      wb = !(it == NONE || it == BRANCH);
      n_cmp++;
      if (out_wb_en !== (wb && dest != 0)) begin
        n_err++; $display("FAIL %s wb_en: got %0b want %0b", tag, out_wb_en, wb && dest != 0);
      end
      n_cmp++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL %s stall: got %0b want 0", tag, stall); end
      if (wb) begin
        n_cmp++;
        if (out_data !== res || out_dest !== dest) begin
          n_err++; $display("FAIL %s wb: got data=%h dest=%0d want data=%h dest=%0d",
                            tag, out_data, out_dest, res, dest);
        end
      end
      return;
    end

    if (m_misaligned(res, mt)) begin
      n_cmp++;
      if (out_misaligned !== 1'b1 || dmem_req_valid !== 1'b0 || stall !== 1'b0 || out_wb_en !== 1'b0) begin
        n_err++; $display("FAIL %s misaligned: got mis=%0b req=%0b stall=%0b wb=%0b want 1 0 0 0",
                          tag, out_misaligned, dmem_req_valid, stall, out_wb_en);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_misaligned !== 1'b0 || dmem_req_valid !== 1'b0 || stall !== 1'b0) begin
        n_err++; $display("FAIL %s misaligned_after: got mis=%0b req=%0b stall=%0b want 0 0 0",
                          tag, out_misaligned, dmem_req_valid, stall);
      end
      return;
    end

    for (int unsigned k = 0; k <= rdy_lat; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (stall !== 1'b1 || dmem_req_valid !== 1'b1 || dmem_we !== is_st ||
          dmem_addr !== exp_addr || dmem_wstrb !== exp_strb || (is_st && dmem_wdata !== exp_wd)) begin
        n_err++; $display("FAIL %s req[%0d]: got stall=%0b v=%0b we=%0b a=%h s=%b d=%h want 1 1 %0b a=%h s=%b d=%h",
                          tag, k, stall, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
                          is_st, exp_addr, exp_strb, exp_wd);
      end
    end
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;

    if (is_st) begin
      n_cmp++;
      if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || out_wb_en !== 1'b0) begin
        n_err++; $display("FAIL %s store_done: got stall=%0b v=%0b wb=%0b want 0 0 0",
                          tag, stall, dmem_req_valid, out_wb_en);
      end
      return;
    end

    for (int unsigned k = 0; k <= rsp_lat; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      n_cmp++;
      if (stall !== 1'b1 || dmem_req_valid !== 1'b0 || out_wb_en !== 1'b0) begin
        n_err++; $display("FAIL %s wait[%0d]: got stall=%0b v=%0b wb=%0b want 1 0 0",
                          tag, k, stall, dmem_req_valid, out_wb_en);
      end
    end
    dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
    n_cmp++;
    if (out_wb_en !== (dest != 0) || out_data !== exp_ld || out_dest !== dest || stall !== 1'b0) begin
      n_err++; $display("FAIL %s load_wb: got wb=%0b data=%h dest=%0d stall=%0b want %0b %h %0d 0",
                        tag, out_wb_en, out_data, out_dest, stall, dest != 0, exp_ld, dest);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_wb_en !== 1'b0) begin n_err++; $display("FAIL %s wb_pulse: got %0b want 0", tag, out_wb_en); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || dmem_we !== 1'b0 ||
        out_wb_en !== 1'b0 || out_misaligned !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got stall=%0b v=%0b we=%0b wb=%0b mis=%0b want all 0",
                        stall, dmem_req_valid, dmem_we, out_wb_en, out_misaligned);
    end
    n_cmp++;
    if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_wstrb !== 4'h0 ||
        out_dest !== 5'd0 || out_data !== 32'h0) begin
      n_err++; $display("FAIL reset_data: got a=%h d=%h s=%b od=%0d odata=%h want all 0",
                        dmem_addr, dmem_wdata, dmem_wstrb, out_dest, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    run_op(LOAD, MEM_W,  5'd3, 32'h0, 32'h100, 0, 1, 32'hDEADBEEF, "lw_100");
    n_cmp++;
    if (out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_value: got %h want deadbeef", out_data); end
    run_op(LOAD, MEM_B,  5'd4, 32'h0, 32'h103, 0, 0, 32'h80123456, "lb_103");
    n_cmp++;
    if (out_data !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_value: got %h want ffffff80", out_data); end
    run_op(LOAD, MEM_BU, 5'd4, 32'h0, 32'h103, 1, 0, 32'h80123456, "lbu_103");
    n_cmp++;
    if (out_data !== 32'h00000080) begin n_err++; $display("FAIL lbu_value: got %h want 00000080", out_data); end
    run_op(LOAD, MEM_H,  5'd6, 32'h0, 32'h102, 0, 2, 32'h80123456, "lh_102");
    n_cmp++;
    if (out_data !== 32'hFFFF8012) begin n_err++; $display("FAIL lh_value: got %h want ffff8012", out_data); end
    run_op(LOAD, MEM_HU, 5'd0, 32'h0, 32'h200, 0, 0, 32'h1234F00D, "lhu_x0");
  endtask

  task automatic test_store_backpressure();
    run_op(STORE, MEM_H, 5'd0, 32'h0000ABCD, 32'h102, 3, 0, 32'h0, "sh_102");
    n_cmp++;
    if (dmem_addr !== 32'h100 || dmem_wstrb !== 4'b1100 || dmem_wdata !== 32'hABCDABCD) begin
      n_err++; $display("FAIL sh_fields: got a=%h s=%b d=%h want 00000100 1100 abcdabcd",
                        dmem_addr, dmem_wstrb, dmem_wdata);
    end
    run_op(STORE, MEM_B, 5'd0, 32'h000000E7, 32'h201, 0, 0, 32'h0, "sb_201");
    run_op(STORE, MEM_W, 5'd0, 32'h13579BDF, 32'h3FC, 1, 0, 32'h0, "sw_3fc");
  endtask

  task automatic test_misaligned();
    run_op(LOAD,  MEM_W,  5'd7, 32'h0, 32'h101, 0, 0, 32'h0, "lw_101");
    run_op(LOAD,  MEM_HU, 5'd7, 32'h0, 32'h103, 0, 0, 32'h0, "lhu_103");
    run_op(STORE, MEM_W,  5'd0, 32'h1,  32'h102, 0, 0, 32'h0, "sw_102");
  endtask

  task automatic test_alu();
    run_op(ALU,    MEM_W, 5'd5, 32'h0, 32'h42,     0, 0, 32'h0, "alu_x5");
    run_op(ALU,    MEM_W, 5'd0, 32'h0, 32'h77,     0, 0, 32'h0, "alu_x0");
    run_op(JAL,    MEM_W, 5'd1, 32'h0, 32'h1004,   0, 0, 32'h0, "jal_x1");
    run_op(BRANCH, MEM_W, 5'd9, 32'h0, 32'h5555,   0, 0, 32'h0, "branch");
  endtask

  task automatic test_reset_in_wait();
    in_instr_type = LOAD; in_mem_type = MEM_W; in_dest = 5'd8; in_res = 32'h400;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    in_instr_type = NONE;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    n_cmp++;
    if (stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_pre: got stall=%0b v=%0b want 1 0", stall, dmem_req_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (stall !== 1'b0 || dmem_req_valid !== 1'b0 || out_wb_en !== 1'b0) begin
      n_err++; $display("FAIL rst_wait: got stall=%0b v=%0b wb=%0b want 0 0 0", stall, dmem_req_valid, out_wb_en);
    end
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_wb_en !== 1'b0 || out_data === 32'hCAFEF00D || stall !== 1'b0) begin
      n_err++; $display("FAIL late_rsp: got wb=%0b data=%h stall=%0b want wb=0 no data stall=0",
                        out_wb_en, out_data, stall);
    end
  endtask

  task automatic test_random();
    instr_type_t it;
    mem_type_t   mt;
    logic [31:0] res;
    for (int n = 0; n < 60; n++) begin
      it  = instr_type_t'($urandom_range(0, 8));
      if ($urandom_range(0, 1) == 1) it = ($urandom_range(0, 1) == 1) ? LOAD : STORE;
      mt  = mem_type_t'($urandom_range(0, 4));
      res = $urandom;
      if ($urandom_range(0, 3) != 0) res[1:0] = (mt == MEM_W) ? 2'b00 :
                                                (mt == MEM_H || mt == MEM_HU) ? {res[1], 1'b0} : res[1:0];
      run_op(it, mt, 5'($urandom_range(0, 31)), $urandom, res,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", n));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_instr_type = NONE; in_mem_type = MEM_W; in_dest = '0;
    in_rs2_data = '0; in_res = '0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    test_reset();
    test_loads();
    test_store_backpressure();
    test_misaligned();
    test_alu();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
